// File: rtl/reg_file_2r1w.sv
// Register file with 2^ADDR_W entries: two combinational read ports and one synchronous write port.
// Register 0 always reads as zero. BYPASS=1 forwards same-cycle write data to a matching read.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  wsel;
    logic [DATA_W-1:0] regs [DEPTH];

    // One-hot write enables; entry 0 is never selected so writes to $0 vanish.
    always_comb begin
        wsel = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wsel[i] = we && (wa == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wsel[i]) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    // Bypass is deliberately not gated by rst: during a reset cycle it still forwards wd.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = regs[ra1];
            if ((BYPASS != 0) && we && (wa == ra1)) begin
                rd1 = wd;
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = regs[ra2];
            if ((BYPASS != 0) && we && (wa == ra2)) begin
                rd2 = wd;
            end
        end
    end

endmodule
